// File: rtl/prbs16_checker.sv
// -----------------------------------------------------------------------------
// prbs16_checker
//
// Receive-side checker for the 16-bit XNOR LFSR data generator
// (x^16 + x^15 + x^13 + x^4, XNOR feedback, left shift). In SEARCH it shifts
// received bits in until 32 consecutive bits agree with the prediction. It
// then enters LOCKED, where it free-runs its own LFSR and compares each
// received bit against it. Too many errors within one observation window
// drop it back to SEARCH.
//
// Ports:
//   CLK        in   system clock, rising edge
//   reset      in   synchronous active-high reset, highest priority
//   din        in   received serial data bit
//   din_valid  in   din is sampled only while high
//   clear_cnt  in   zeroes err_count and bit_count, overriding any increment
//   locked     out  high while in LOCKED
//   err_pulse  out  registered one-cycle pulse per mismatched bit in LOCKED
//   err_count  out  saturating total error count
//   bit_count  out  wrapping count of bits checked in LOCKED
// -----------------------------------------------------------------------------
module prbs16_checker #(
    parameter int unsigned LOCK_COUNT = 32,
    parameter int unsigned WINDOW     = 256,
    parameter int unsigned ERR_LIMIT  = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
);

    localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned WBITS_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int unsigned WERRS_W = $clog2(ERR_LIMIT + 1);

    localparam logic [MATCH_W-1:0] MATCH_TARGET = MATCH_W'(LOCK_COUNT);
    localparam logic [WBITS_W-1:0] WBITS_LAST   = WBITS_W'(WINDOW - 1);
    localparam logic [WERRS_W-1:0] WERRS_LIMIT  = WERRS_W'(ERR_LIMIT);

    localparam logic ST_SEARCH = 1'b0;
    localparam logic ST_LOCKED = 1'b1;

    logic               r_state;
    logic [15:0]        r_s;
    logic [4:0]         r_fill;
    logic [MATCH_W-1:0] r_match_cnt;
    logic [WBITS_W-1:0] r_win_bits;
    logic [WERRS_W-1:0] r_win_errs;
    logic               r_err_pulse;
    logic [CNT_W-1:0]   r_err_count;
    logic [CNT_W-1:0]   r_bit_count;

    logic               w_pred;
    logic               w_err;
    logic               w_fill_done;
    logic               w_lockup;
    logic [MATCH_W-1:0] w_match_inc;
    logic [WERRS_W-1:0] w_win_errs_sum;
    logic               w_lose_lock;
    logic               w_err_sat;
    logic               w_check;

    always_comb begin
        w_pred         = ~(r_s[15] ^ r_s[14] ^ r_s[12] ^ r_s[3]);
        w_err          = din ^ w_pred;
        w_fill_done    = r_fill[4];
        // All-ones is the XNOR lock-up state: it predicts itself forever.
        w_lockup       = (r_s == 16'hFFFF);
        w_match_inc    = r_match_cnt + MATCH_W'(1);
        // Sum cannot overflow: r_win_errs stays below ERR_LIMIT while locked.
        w_win_errs_sum = r_win_errs + WERRS_W'(w_err);
        w_lose_lock    = (w_win_errs_sum >= WERRS_LIMIT);
        w_err_sat      = &r_err_count;
        w_check        = din_valid && (r_state == ST_LOCKED);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state     <= ST_SEARCH;
            r_s         <= 16'h0000;
            r_fill      <= 5'd0;
            r_match_cnt <= '0;
            r_win_bits  <= '0;
            r_win_errs  <= '0;
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
            r_bit_count <= '0;
        end else begin
            r_err_pulse <= w_check && w_err;

            if (clear_cnt) begin
                r_err_count <= '0;
                r_bit_count <= '0;
            end else if (w_check) begin
                r_bit_count <= r_bit_count + CNT_W'(1);
                if (w_err && !w_err_sat) begin
                    r_err_count <= r_err_count + CNT_W'(1);
                end
            end

            if (din_valid) begin
                case (r_state)
                    ST_SEARCH: begin
                        r_s <= {r_s[14:0], din};
                        if (!w_fill_done) begin
                            r_fill      <= r_fill + 5'd1;
                            r_match_cnt <= '0;
                        end else if (w_lockup || w_err) begin
                            r_match_cnt <= '0;
                        end else begin
                            r_match_cnt <= w_match_inc;
                            if (w_match_inc == MATCH_TARGET) begin
                                r_state    <= ST_LOCKED;
                                r_win_bits <= '0;
                                r_win_errs <= '0;
                            end
                        end
                    end
                    default: begin
                        // Flywheel: keep running our own sequence so that a
                        // corrupted bit does not propagate into later predictions.
                        r_s <= {r_s[14:0], w_pred};
                        if (w_lose_lock) begin
                            r_state     <= ST_SEARCH;
                            r_fill      <= 5'd0;
                            r_match_cnt <= '0;
                        end
                        // The last bit of a window is judged against that window
                        // (above) before the window restarts.
                        if (r_win_bits == WBITS_LAST) begin
                            r_win_bits <= '0;
                            r_win_errs <= '0;
                        end else begin
                            r_win_bits <= r_win_bits + WBITS_W'(1);
                            r_win_errs <= w_win_errs_sum;
                        end
                    end
                endcase
            end
        end
    end

    assign locked    = (r_state == ST_LOCKED);
    assign err_pulse = r_err_pulse;
    assign err_count = r_err_count;
    assign bit_count = r_bit_count;

endmodule
